score_pack_loader: RTL and testbench



---
 rtl/num_sort_pkg.sv | 23 ++
 rtl/rise_detect.sv | 19 +
 rtl/score_pack_loader.sv | 122 ++++++++++++
 tb/tb_score_pack_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/num_sort_pkg.sv
// Shared definitions for the score sorter and its upstream loader.
// Holds frame geometry, the loader state set and slot offset math.
package num_sort_pkg;

  localparam int NUM_CLASS = 10;
  localparam int DATA_W    = 16;
  localparam int IDX_W     = 4;
  localparam int BUS_W     = NUM_CLASS * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    LOAD,
    WAIT
  } state_e;

  function automatic int unsigned slot_off(
    input int unsigned k
  );
    return k * DATA_W;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a level input.
// rise_o is combinational from d_i and the registered copy.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/score_pack_loader.sv
// Serial score collector feeding the 10-way sorter's packed bus.
// Holds load for a fixed count, then waits on complete or timeout.
module score_pack_loader
  import num_sort_pkg::*;
#(
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [BUS_W-1:0]  data,
  output logic              load,
  input  logic              complete,
  output logic              busy,
  output logic              frame_err
);

  localparam int LC_W = $clog2(LOAD_CYCLES + 1);
  localparam int TM_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [BUS_W-1:0]  shadow_q, shadow_d;
  logic [BUS_W-1:0]  data_q, data_d;
  logic [LC_W-1:0]   lcnt_q, lcnt_d;
  logic [TM_W-1:0]   tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic              done;
  logic              accept;

  rise_detect u_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (complete),
    .rise_o (done)
  );

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    lcnt_d   = lcnt_q;
    tcnt_d   = tcnt_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: state_d = COLLECT;
      COLLECT: begin
        if (accept) begin
          shadow_d[slot_off(int'(cnt_q)) +: DATA_W] = in_data;
          if (cnt_q == IDX_W'(NUM_CLASS - 1)) begin
            // slot count decides the frame; a missing last only flags it
            data_d  = shadow_d;
            cnt_d   = '0;
            lcnt_d  = '0;
            err_d   = ~in_last;
            state_d = LOAD;
          end else if (in_last) begin
            err_d    = 1'b1;
            cnt_d    = '0;
            shadow_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD: begin
        if (lcnt_q == LC_W'(LOAD_CYCLES - 1)) begin
          lcnt_d  = '0;
          tcnt_d  = '0;
          state_d = WAIT;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (done) begin
          state_d = COLLECT;
        end else if (tcnt_q == TM_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = COLLECT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      lcnt_q   <= '0;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      lcnt_q   <= lcnt_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign busy      = (state_q != COLLECT);
  assign load      = (state_q == LOAD);
  assign data      = data_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_score_pack_loader.sv
// Scoreboard bench for score_pack_loader with a frame-level model.
module tb_score_pack_loader;
  import num_sort_pkg::*;

  localparam int BW   = NUM_CLASS * DATA_W;
  localparam int LCYC = 2;
  localparam int TMO  = 1023;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic [BW-1:0]     data;
  logic              load;
  logic              complete;
  logic              busy;
  logic              frame_err;

  score_pack_loader #(.LOAD_CYCLES(LCYC), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .data      (data),
    .load      (load),
    .complete  (complete),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            err;
    bit            ld;
    logic [BW-1:0] data;
  } exp_t;

  exp_t              expq[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                slot_idx = 0;
  logic [DATA_W-1:0] slots[NUM_CLASS];
  logic [DATA_W-1:0] fr[NUM_CLASS];

  task automatic chk(input string nm, input logic [BW-1:0] act,
                     input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Frame-level model: a full slot set loads, an early last drops it.
  task automatic model_beat(input logic [DATA_W-1:0] d, input bit last);
    exp_t e;
    slots[slot_idx] = d;
    if (slot_idx == NUM_CLASS - 1) begin
      e.err = !last;
      e.ld = 1'b1;
      e.data = '0;
      for (int k = 0; k < NUM_CLASS; k++)
        e.data[k*DATA_W +: DATA_W] = slots[k];
      expq.push_back(e);
      slot_idx = 0;
    end else if (last) begin
      e.err = 1'b1;
      e.ld = 1'b0;
      e.data = '0;
      expq.push_back(e);
      slot_idx = 0;
    end else begin
      slot_idx++;
    end
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input bit last,
                           output int waited);
    model_beat(d, last);
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    waited = 0;
    while (!in_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("beat_accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit last_end,
                            input bit gaps, input bit rnd_cpl,
                            output int first_wait);
    int w;
    first_wait = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0)
        repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(fr[i], last_end && (i == n - 1), w);
      if (i == 0) first_wait = w;
      complete = rnd_cpl ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic finish_wait(input bit tmo, input bit b2b);
    int n;
    exp_t e;
    chk("load_after_accept", load, 1);
    n = 0;
    while (load && n < 20) begin
      @(negedge clk);
      n++;
    end
    complete = 1'b0;
    if (tmo) begin
      e.err = 1'b1;
      e.ld = 1'b0;
      e.data = '0;
      expq.push_back(e);
      n = 0;
      while (!in_ready && n < 1100) begin
        n++;
        @(negedge clk);
      end
      chk("timeout_len", n, TMO);
      chk("busy_after_timeout", busy, 0);
    end else begin
      repeat ($urandom_range(1, 5)) begin
        chk("ready_low_in_wait", in_ready, 0);
        @(negedge clk);
      end
      complete = 1'b1;
      if (!b2b) begin
        @(negedge clk);
        chk("ready_after_done", in_ready, 1);
        complete = 1'b0;
      end
    end
  endtask

  // Monitor: pops one expectation per observed frame outcome.
  bit prev_load = 1'b0;
  bit prev_err = 1'b0;
  int run = 0;
  logic [BW-1:0] exp_data = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      run = 0;
      exp_data = '0;
    end else begin
      if (frame_err || (load && !prev_load)) begin
        if (expq.size() == 0) begin
          chk("unexpected_event", {frame_err, load}, 0);
        end else begin
          e = expq.pop_front();
          chk("ev_err", frame_err, e.err);
          chk("ev_load", load && !prev_load, e.ld);
          if (e.ld) exp_data = e.data;
        end
      end
      chk("data_hold", data, exp_data);
      if (frame_err && prev_err) chk("err_double", 1, 0);
      if (load) begin
        run++;
      end else if (run != 0) begin
        chk("load_len", run, LCYC);
        run = 0;
      end
    end
    prev_load = load;
    prev_err = frame_err;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int fw;
    int n;
    int kind;
    bit lst;
    logic [BW-1:0] gold;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    complete = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_load", load, 0);
    chk("rst_data", data, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err", frame_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_idle", in_ready, 1);

    fr = '{16'h0004, 16'h0001, 16'h0002, 16'h0003, 16'h0009,
           16'h0005, 16'h0000, 16'h0007, 16'h0008, 16'h0006};
    send_frame(NUM_CLASS, 1, 0, 0, fw);
    gold = 160'h0006_0008_0007_0000_0005_0009_0003_0002_0001_0004;
    chk("directed_data", data, gold);
    finish_wait(0, 0);

    for (int i = 0; i < NUM_CLASS; i++) fr[i] = '0;
    fr[3] = 16'hFFF6;
    send_frame(NUM_CLASS, 1, 0, 0, fw);
    chk("neg_slot3", data[63:48], 16'hFFF6);
    finish_wait(0, 0);

    for (int i = 0; i < NUM_CLASS; i++) fr[i] = DATA_W'($urandom);
    send_frame(4, 1, 0, 0, fw);
    repeat (2) @(negedge clk);
    chk("no_load_early", load, 0);
    for (int i = 0; i < NUM_CLASS; i++) fr[i] = DATA_W'($urandom);
    send_frame(NUM_CLASS, 1, 1, 0, fw);
    finish_wait(0, 0);

    for (int i = 0; i < NUM_CLASS; i++) fr[i] = DATA_W'($urandom);
    send_frame(NUM_CLASS, 0, 0, 0, fw);
    finish_wait(0, 0);

    for (int i = 0; i < NUM_CLASS; i++) fr[i] = DATA_W'($urandom);
    send_frame(NUM_CLASS, 1, 0, 0, fw);
    finish_wait(1, 0);
    for (int i = 0; i < NUM_CLASS; i++) fr[i] = DATA_W'($urandom);
    send_frame(NUM_CLASS, 1, 0, 0, fw);
    finish_wait(0, 1);
    for (int i = 0; i < NUM_CLASS; i++) fr[i] = DATA_W'($urandom);
    send_frame(NUM_CLASS, 1, 0, 0, fw);
    chk("b2b_first_wait", fw, 1);
    finish_wait(0, 0);

    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 7);
      n = (kind == 0) ? $urandom_range(1, NUM_CLASS - 1) : NUM_CLASS;
      lst = (kind != 1);
      for (int i = 0; i < NUM_CLASS; i++) fr[i] = DATA_W'($urandom);
      send_frame(n, lst, 1, 1, fw);
      if (n == NUM_CLASS) finish_wait(0, 0);
      else repeat (2) @(negedge clk);
    end
    complete = 1'b0;

    for (int i = 0; i < NUM_CLASS; i++) fr[i] = DATA_W'($urandom);
    send_frame(NUM_CLASS, 1, 0, 0, fw);
    chk("load_before_rst", load, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_load", load, 0);
    chk("midrst_data", data, 0);
    chk("midrst_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("postrst_ready0", in_ready, 0);
    @(negedge clk);
    chk("postrst_ready1", in_ready, 1);

    for (int i = 0; i < NUM_CLASS; i++) fr[i] = DATA_W'($urandom);
    send_frame(NUM_CLASS, 1, 1, 0, fw);
    finish_wait(0, 0);

    repeat (4) @(negedge clk);
    chk("queue_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
